fetch_queue: RTL



---
 rtl/fetch_queue.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches words from the shared memory when the data
// stage is idle and presents them to decode through a valid/ready handshake.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data_busy,
  output logic                       mem_fetch,
  output logic [ADDR_W-1:0]          mem_addr,
  input  logic [31:0]                mem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [31:0]                inst_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                fetch_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [31:0] NopInst = 32'h0000_0033;

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic full;
  logic pop;

  assign full       = (count_q == CntW'(DEPTH));
  // Data accesses and redirects always take precedence over a fetch.
  assign mem_fetch  = rst & ~data_busy & ~full & ~redirect;
  assign mem_addr   = fetch_pc_q[ADDR_W+1:2];
  assign inst_valid = (count_q != '0) & ~redirect;
  assign pop        = inst_valid & inst_ready;
  assign count      = count_q;
  assign fetch_pc   = fetch_pc_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = redirect_pc & ~32'h0000_0003;
    end else begin
      if (mem_fetch) begin
        wr_ptr_d   = wr_ptr_q + PtrW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({mem_fetch, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_PC;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (mem_fetch) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      inst_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  always_comb begin
    inst    = NopInst;
    inst_pc = 32'd0;
    if (inst_valid) begin
      inst    = inst_mem[rd_ptr_q];
      inst_pc = pc_mem[rd_ptr_q];
    end
  end

  assign inst_pc_plus4 = inst_pc + 32'd4;

endmodule
